// File: rtl/mod_inv_arbiter.sv
// -----------------------------------------------------------------------------
// mod_inv_arbiter
//
// Round-robin arbiter and sequencer that shares one multiplicative-inverse unit
// between NUM_REQ requesters. One request is accepted at a time. Its operands
// are registered and driven to the unit. After UNIT_LAT cycles the unit result
// is captured and returned to the winner over a valid/ready handshake.
//
// Parameters:
//   NUM_REQ   number of requesters (2..8)
//   DATA_W    operand/result width
//   UNIT_LAT  shared-unit latency in cycles (0 = combinational)
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   req_valid / req_ready      per-requester request handshake (ready one-hot)
//   req_num / req_mod          flattened operands, requester i at [i*DATA_W +: DATA_W]
//   unit_num / unit_modulo     registered operands to the shared unit
//   unit_inverse / unit_valid  result from the shared unit
//   resp_valid / resp_ready    per-requester response handshake (valid one-hot)
//   resp_inverse / resp_ok     captured unit result
//   busy                       high whenever the FSM is not idle
//   stat_done / stat_fail      response counters (only with MOD_INV_STATS_EN)
//
// Optional feature macro: MOD_INV_STATS_EN
// -----------------------------------------------------------------------------
module mod_inv_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 64,
  parameter int UNIT_LAT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_num,
  input  logic [NUM_REQ*DATA_W-1:0] req_mod,
  output logic [DATA_W-1:0]         unit_num,
  output logic [DATA_W-1:0]         unit_modulo,
  input  logic [DATA_W-1:0]         unit_inverse,
  input  logic                      unit_valid,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_inverse,
  output logic                      resp_ok,
`ifdef MOD_INV_STATS_EN
  output logic [31:0]               stat_done,
  output logic [31:0]               stat_fail,
`endif
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (UNIT_LAT == 0) ? 1 : $clog2(UNIT_LAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] num_q, num_d;
  logic [DATA_W-1:0] mod_q, mod_d;
  logic [DATA_W-1:0] inv_q, inv_d;
  logic              ok_q, ok_d;

  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand;
  logic              resp_fire;

  // Rotating priority search: first valid requester at or above rr_ptr, with wrap.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand = IDX_W'((int'(rr_ptr_q) + j) % NUM_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign resp_fire = (state_q == S_RESP) && resp_ready[gnt_q];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    mod_d    = mod_q;
    inv_d    = inv_q;
    ok_d     = ok_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          num_d    = req_num[int'(grant_idx)*DATA_W +: DATA_W];
          mod_d    = req_mod[int'(grant_idx)*DATA_W +: DATA_W];
          gnt_d    = grant_idx;
          rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
          cnt_d    = CNT_W'(UNIT_LAT);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // The operands have been stable since the accept edge, so once the
        // countdown expires the unit output is valid and can be sampled.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          inv_d   = unit_inverse;
          ok_d    = unit_valid;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state, including the operand and result registers, is reset so
  // the unit sees zeros and the response outputs read zero right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      mod_q    <= '0;
      inv_q    <= '0;
      ok_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      mod_q    <= mod_d;
      inv_q    <= inv_d;
      ok_q     <= ok_d;
    end
  end

  // req_ready is gated by rst so every output reads zero while reset is held,
  // even if a requester keeps its request asserted.
  assign req_ready    = (state_q == S_IDLE && grant_vld && !rst)
                        ? (NUM_REQ'(1) << grant_idx) : '0;
  assign resp_valid   = (state_q == S_RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign unit_num     = num_q;
  assign unit_modulo  = mod_q;
  assign resp_inverse = inv_q;
  assign resp_ok      = ok_q;
  assign busy         = (state_q != S_IDLE);

`ifdef MOD_INV_STATS_EN
  logic [31:0] stat_done_q;
  logic [31:0] stat_fail_q;

  // Saturating counters of accepted responses and of failed ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_done_q <= '0;
      stat_fail_q <= '0;
    end else if (resp_fire) begin
      if (stat_done_q != '1) stat_done_q <= stat_done_q + 1'b1;
      if (!ok_q && stat_fail_q != '1) stat_fail_q <= stat_fail_q + 1'b1;
    end
  end

  assign stat_done = stat_done_q;
  assign stat_fail = stat_fail_q;
`endif

endmodule

// File: tb/tb_mod_inv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mod_inv_arbiter
//
// Two arbiter instances share one clock: index 0 with UNIT_LAT=0, index 1 with
// UNIT_LAT=3. Each has its own behavioural inverse unit (extended Euclid,
// delayed by UNIT_LAT). Expected grants come from a rotating-priority model
// over a pending-request set. Expected inverses come from a brute-force search.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mod_inv_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;
  localparam int NDUT    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0]                     rst;
  logic [NDUT-1:0][NUM_REQ-1:0]        req_valid, req_ready, resp_valid, resp_ready;
  logic [NDUT-1:0][NUM_REQ*DATA_W-1:0] req_num, req_mod;
  logic [NDUT-1:0][DATA_W-1:0]         unit_num, unit_modulo, unit_inverse, resp_inverse;
  logic [NDUT-1:0]                     unit_valid, resp_ok, busy;
`ifdef MOD_INV_STATS_EN
  logic [NDUT-1:0][31:0]               stat_done, stat_fail;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state.
  logic [NDUT-1:0][NUM_REQ-1:0] pend;
  int                           rr_m   [NDUT];
  logic [DATA_W-1:0]            num_m  [NDUT][NUM_REQ];
  logic [DATA_W-1:0]            mod_m  [NDUT][NUM_REQ];
  int                           done_m [NDUT];
  int                           fail_m [NDUT];

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Behavioural inverse unit: {exists, inverse} by extended Euclid.
  function automatic logic [DATA_W:0] unit_fn(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] m);
    longint t, nt, r, nr, q, tmp;
    if (m == '0) return '0;
    t  = 0;
    nt = 1;
    r  = longint'(m);
    nr = longint'(a % m);
    while (nr != 0) begin
      q   = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    if (r != 1) return '0;
    if (t < 0) t = t + longint'(m);
    return {1'b1, DATA_W'(t)};
  endfunction

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int LK = (k == 0) ? 0 : 3;
    logic [DATA_W:0] comb_res;

    mod_inv_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .DATA_W   (DATA_W),
      .UNIT_LAT (LK)
    ) u_dut (
      .clk          (clk),
      .rst          (rst[k]),
      .req_valid    (req_valid[k]),
      .req_ready    (req_ready[k]),
      .req_num      (req_num[k]),
      .req_mod      (req_mod[k]),
      .unit_num     (unit_num[k]),
      .unit_modulo  (unit_modulo[k]),
      .unit_inverse (unit_inverse[k]),
      .unit_valid   (unit_valid[k]),
      .resp_valid   (resp_valid[k]),
      .resp_ready   (resp_ready[k]),
      .resp_inverse (resp_inverse[k]),
      .resp_ok      (resp_ok[k]),
`ifdef MOD_INV_STATS_EN
      .stat_done    (stat_done[k]),
      .stat_fail    (stat_fail[k]),
`endif
      .busy         (busy[k])
    );

    assign comb_res = unit_fn(unit_num[k], unit_modulo[k]);

    if (LK == 0) begin : g_comb
      assign unit_inverse[k] = comb_res[DATA_W-1:0];
      assign unit_valid[k]   = comb_res[DATA_W];
    end else begin : g_pipe
      logic [DATA_W:0] pipe [LK];
      always @(posedge clk) begin
        pipe[0] <= comb_res;
        for (int s = 1; s < LK; s++) pipe[s] <= pipe[s-1];
      end
      assign unit_inverse[k] = pipe[LK-1][DATA_W-1:0];
      assign unit_valid[k]   = pipe[LK-1][DATA_W];
    end
  end

  task automatic check(input int k, input string name,
                       input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL d%0d/%s observed=%0h expected=%0h", k, name, obs, exp);
    end
  endtask

  // Reference inverse by exhaustive search (moduli in the bench are small).
  function automatic void ref_inv(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] m,
                                  output logic [DATA_W-1:0] inv, output logic ok);
    inv = '0;
    ok  = 1'b0;
    for (longint unsigned x = 1; x < m; x++) begin
      if (((a % m) * x) % m == 1) begin
        inv = x;
        ok  = 1'b1;
        break;
      end
    end
  endfunction

  // Rotating priority: first pending requester at or after the model pointer.
  function automatic int winner(input int k);
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pend[k][(rr_m[k] + j) % NUM_REQ]) return (rr_m[k] + j) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input int i,
                         input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] m);
    num_m[k][i] = n;
    mod_m[k][i] = m;
    req_num[k][i*DATA_W +: DATA_W] = n;
    req_mod[k][i*DATA_W +: DATA_W] = m;
    pend[k][i]   = 1'b1;
    req_valid[k] = pend[k];
  endtask

  task automatic drop_req(input int k, input int i);
    pend[k][i]   = 1'b0;
    req_valid[k] = pend[k];
  endtask

  // Called at posedge+1 with the DUT idle; runs one complete transaction.
  task automatic serve(input int k, input int bp, input bit keep);
    int g, n;
    logic [NUM_REQ-1:0] oh;
    logic [DATA_W-1:0]  e_inv, e_num, e_mod;
    logic               e_ok;
    #1;
    g = winner(k);
    if (g < 0) return;
    oh    = NUM_REQ'(1) << g;
    e_num = num_m[k][g];
    e_mod = mod_m[k][g];
    ref_inv(e_num, e_mod, e_inv, e_ok);
    check(k, "req_ready_grant", req_ready[k], oh);
    check(k, "busy_idle", busy[k], 1'b0);

    @(posedge clk); #1;
    rr_m[k] = (g + 1) % NUM_REQ;
    if (!keep) drop_req(k, g);
    check(k, "busy_after_accept", busy[k], 1'b1);
    check(k, "unit_num", unit_num[k], e_num);
    check(k, "unit_modulo", unit_modulo[k], e_mod);

    n = 0;
    while (resp_valid[k] == '0 && n < 64) begin
      check(k, "req_ready_wait", req_ready[k], '0);
      @(posedge clk); #1;
      n++;
    end
    check(k, "resp_latency", n, lat_of(k) + 1);
    check(k, "resp_valid", resp_valid[k], oh);
    check(k, "resp_inverse", resp_inverse[k], e_inv);
    check(k, "resp_ok", resp_ok[k], e_ok);

    repeat (bp) begin
      resp_ready[k] = NUM_REQ'($urandom) & ~oh;
      @(posedge clk); #1;
      check(k, "bp_resp_valid", resp_valid[k], oh);
      check(k, "bp_resp_inverse", resp_inverse[k], e_inv);
      check(k, "bp_resp_ok", resp_ok[k], e_ok);
      check(k, "bp_req_ready", req_ready[k], '0);
    end

    resp_ready[k] = oh;
    @(posedge clk); #1;
    resp_ready[k] = '0;
    check(k, "resp_valid_clear", resp_valid[k], '0);
    check(k, "busy_clear", busy[k], 1'b0);
    done_m[k]++;
    if (!e_ok) fail_m[k]++;
`ifdef MOD_INV_STATS_EN
    check(k, "stat_done", stat_done[k], done_m[k]);
    check(k, "stat_fail", stat_fail[k], fail_m[k]);
`endif
  endtask

  task automatic check_all_zero(input int k, input string name);
    check(k, {name, "_req_ready"}, req_ready[k], '0);
    check(k, {name, "_resp_valid"}, resp_valid[k], '0);
    check(k, {name, "_busy"}, busy[k], 1'b0);
    check(k, {name, "_unit_num"}, unit_num[k], '0);
    check(k, {name, "_unit_modulo"}, unit_modulo[k], '0);
    check(k, {name, "_resp_inverse"}, resp_inverse[k], '0);
    check(k, {name, "_resp_ok"}, resp_ok[k], 1'b0);
`ifdef MOD_INV_STATS_EN
    check(k, {name, "_stat_done"}, stat_done[k], '0);
    check(k, {name, "_stat_fail"}, stat_fail[k], '0);
`endif
  endtask

  initial begin
    int seen;
    rst        = '1;
    req_valid  = '0;
    resp_ready = '0;
    req_num    = '0;
    req_mod    = '0;
    pend       = '0;
    for (int k = 0; k < NDUT; k++) begin
      rr_m[k]   = 0;
      done_m[k] = 0;
      fail_m[k] = 0;
    end
    #1;
    for (int k = 0; k < NDUT; k++) check_all_zero(k, "reset");
    repeat (2) @(posedge clk);
    #1;
    rst = '0;

    for (int k = 0; k < NDUT; k++) begin
      // Fairness: all requesters held continuously -> grants 0,1,2,3,0.
      for (int i = 0; i < NUM_REQ; i++) set_req(k, i, 10, 17);
      repeat (5) serve(k, 0, 1'b1);
      for (int i = 0; i < NUM_REQ; i++) drop_req(k, i);

      // Single request: 3^-1 mod 11.
      set_req(k, 2, 3, 11);
      serve(k, 0, 1'b0);

      // Non-invertible: gcd(4,8) != 1.
      set_req(k, 0, 4, 8);
      serve(k, 0, 1'b0);

      // Backpressure with another requester waiting.
      set_req(k, 1, 7, 13);
      set_req(k, 3, 5, 9);
      serve(k, 5, 1'b0);
      serve(k, 0, 1'b0);

      // Random traffic: random request sets, backpressure and re-requests.
      for (int r = 0; r < 25; r++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!pend[k][i] && $urandom_range(0, 1) == 1)
            set_req(k, i, $urandom_range(0, 300), $urandom_range(2, 200));
        end
        if (pend[k] == '0) set_req(k, $urandom_range(0, NUM_REQ - 1),
                                   $urandom_range(0, 300), $urandom_range(2, 200));
        serve(k, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < NUM_REQ; i++) drop_req(k, i);

      // Reset one cycle into WAIT abandons the transaction.
      if (k == 1) begin
        set_req(k, 3, 5, 7);
        #1;
        @(posedge clk); #1;
        drop_req(k, 3);
        @(posedge clk); #1;
        rst[k] = 1'b1;
        #1;
        check_all_zero(k, "midreset");
        @(posedge clk); #1;
        rst[k]    = 1'b0;
        rr_m[k]   = 0;
        done_m[k] = 0;
        fail_m[k] = 0;
        seen      = 0;
        repeat (6) begin
          @(posedge clk); #1;
          if (resp_valid[k] != '0) seen++;
        end
        check(k, "no_resp_after_reset", seen, 0);
        set_req(k, 1, 10, 17);
        serve(k, 0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
